// File: rtl/clk_meas_pkg.sv
// Shared types and default configuration for the clock ratio meter.
package clk_meas_pkg;

   typedef enum logic [0:0] {
      SEEK  = 1'b0,
      COUNT = 1'b1
   } meas_state_t;

   localparam int DEF_WIDTH       = 32;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_LOCK_COUNT  = 4;
   localparam int DEF_TIMEOUT_MAX = 50_000_000;

endpackage

// File: rtl/sig_edge_sync.sv
// Reset-to-one synchronizer for an asynchronous input, with rise/fall detection
// on the synchronized value.
module sig_edge_sync
   import clk_meas_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset,
   input  logic sig_in,
   output logic s,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain_r;
   logic                   s_d_r;

   // Synchronizer chain and delayed copy; reset high so a high input gives no false rise
   always_ff @(posedge clk) begin
      if (reset) begin
         chain_r <= {SYNC_STAGES{1'b1}};
         s_d_r   <= 1'b1;
      end else begin
         chain_r <= {chain_r[SYNC_STAGES-2:0], sig_in};
         s_d_r   <= chain_r[SYNC_STAGES-1];
      end
   end

   assign s    = chain_r[SYNC_STAGES-1];
   assign rise = s & ~s_d_r;
   assign fall = ~s & s_d_r;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period (and, with CLK_RATIO_METER_DUTY_MEASURE_EN, high time) of a slow
// signal in clk cycles, with lock and timeout status.
module clk_ratio_meter
   import clk_meas_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
   parameter int TIMEOUT_MAX = DEF_TIMEOUT_MAX
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sig_in,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             timeout
);

   localparam int               MW        = $clog2(LOCK_COUNT + 1);
   localparam logic [MW-1:0]    LOCK_MAX  = MW'(LOCK_COUNT);
   localparam logic [MW-1:0]    MATCH_ONE = {{(MW-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] CNT_MAX   = WIDTH'(TIMEOUT_MAX);
   localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

   meas_state_t      state_r, state_next_s;
   logic [WIDTH-1:0] cnt_r, cnt_next_s;
   logic [WIDTH-1:0] period_r, period_next_s;
   logic [MW-1:0]    match_r, match_next_s;
   logic             meas_valid_r, meas_valid_next_s;
   logic             locked_r;
   logic             timeout_r, timeout_next_s;
   logic             s_s, rise_s, fall_s;
   logic             sync_unused_s;

`ifdef CLK_RATIO_METER_DUTY_MEASURE_EN
   logic [WIDTH-1:0] high_time_r, high_time_next_s;
   logic [WIDTH-1:0] hi_tmp_r, hi_tmp_next_s;
   logic             fall_seen_r, fall_seen_next_s;
`endif

   sig_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .reset  (reset),
      .sig_in (sig_in),
      .s      (s_s),
      .rise   (rise_s),
      .fall   (fall_s)
   );

`ifdef CLK_RATIO_METER_DUTY_MEASURE_EN
   assign sync_unused_s = s_s;
`else
   assign sync_unused_s = s_s ^ fall_s;
`endif

   // Next-state, counter, match and measurement logic
   always_comb begin
      state_next_s      = state_r;
      cnt_next_s        = cnt_r;
      period_next_s     = period_r;
      match_next_s      = match_r;
      meas_valid_next_s = 1'b0;
      timeout_next_s    = timeout_r;
`ifdef CLK_RATIO_METER_DUTY_MEASURE_EN
      high_time_next_s  = high_time_r;
      hi_tmp_next_s     = hi_tmp_r;
      fall_seen_next_s  = fall_seen_r;
`endif
      case (state_r)
         SEEK: begin
            if (rise_s) begin
               state_next_s   = COUNT;
               cnt_next_s     = CNT_ONE;
               timeout_next_s = 1'b0;
`ifdef CLK_RATIO_METER_DUTY_MEASURE_EN
               fall_seen_next_s = 1'b0;
`endif
            end else begin
               state_next_s = SEEK;
            end
         end
         COUNT: begin
            if (rise_s) begin
               period_next_s     = cnt_r;
               meas_valid_next_s = 1'b1;
               cnt_next_s        = CNT_ONE;
               // match_r is zero until a measurement exists since reset or timeout
               if ((match_r != {MW{1'b0}}) && (cnt_r == period_r)) begin
                  match_next_s = (match_r == LOCK_MAX) ? LOCK_MAX : (match_r + MATCH_ONE);
               end else begin
                  match_next_s = MATCH_ONE;
               end
`ifdef CLK_RATIO_METER_DUTY_MEASURE_EN
               high_time_next_s = fall_seen_r ? hi_tmp_r : cnt_r;
               fall_seen_next_s = 1'b0;
`endif
            end else if (cnt_r == CNT_MAX) begin
               timeout_next_s = 1'b1;
               match_next_s   = {MW{1'b0}};
               state_next_s   = SEEK;
            end else begin
               cnt_next_s = cnt_r + CNT_ONE;
`ifdef CLK_RATIO_METER_DUTY_MEASURE_EN
               if (fall_s) begin
                  hi_tmp_next_s    = cnt_r;
                  fall_seen_next_s = 1'b1;
               end else begin
                  fall_seen_next_s = fall_seen_r;
               end
`endif
            end
         end
         default: begin
            state_next_s = SEEK;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= SEEK;
         cnt_r        <= {WIDTH{1'b0}};
         period_r     <= {WIDTH{1'b0}};
         match_r      <= {MW{1'b0}};
         meas_valid_r <= 1'b0;
         locked_r     <= 1'b0;
         timeout_r    <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         cnt_r        <= cnt_next_s;
         period_r     <= period_next_s;
         match_r      <= match_next_s;
         meas_valid_r <= meas_valid_next_s;
         locked_r     <= (match_next_s == LOCK_MAX);
         timeout_r    <= timeout_next_s;
      end
   end

`ifdef CLK_RATIO_METER_DUTY_MEASURE_EN
   // High-time capture registers
   always_ff @(posedge clk) begin
      if (reset) begin
         high_time_r <= {WIDTH{1'b0}};
         hi_tmp_r    <= {WIDTH{1'b0}};
         fall_seen_r <= 1'b0;
      end else begin
         high_time_r <= high_time_next_s;
         hi_tmp_r    <= hi_tmp_next_s;
         fall_seen_r <= fall_seen_next_s;
      end
   end

   assign high_time = high_time_r;
`else
   assign high_time = {WIDTH{1'b0}};
`endif

   assign period     = period_r;
   assign meas_valid = meas_valid_r;
   assign locked     = locked_r;
   assign timeout    = timeout_r;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Self-checking bench for clk_ratio_meter: timestamp-based reference model of
// edges, periods, lock and timeout, compared every cycle plus scenario checks.
module tb_clk_ratio_meter;

   localparam int W    = 16;
   localparam int S    = 2;
   localparam int LC   = 4;
   localparam int TM   = 100;
   localparam int MAXE = 16384;
`ifdef CLK_RATIO_METER_DUTY_MEASURE_EN
   localparam bit DUTY = 1'b1;
`else
   localparam bit DUTY = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         sig_in = 1'b0;
   logic [W-1:0] period, high_time;
   logic         meas_valid, locked, timeout;

   clk_ratio_meter #(
      .WIDTH (W), .SYNC_STAGES (S), .LOCK_COUNT (LC), .TIMEOUT_MAX (TM)
   ) dut (
      .clk (clk), .reset (reset), .sig_in (sig_in), .period (period),
      .high_time (high_time), .meas_valid (meas_valid), .locked (locked), .timeout (timeout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: edge index k, sampled input history, rise/fall timestamps
   bit samp [MAXE];
   int k = 0, rst_edge = 0, start_k = 0, fall_k = 0, match = 0;
   int exp_period = 0, exp_high = 0;
   bit seeking = 1'b1, fall_seen = 1'b0, have_prev = 1'b0, exp_mv = 1'b0, exp_timeout = 1'b0;

   logic [2*W+2:0] obs, expv;
   assign obs  = {meas_valid, locked, timeout, period, high_time};
   assign expv = {exp_mv, (match == LC), exp_timeout, W'(exp_period), W'(exp_high)};

   // Synchronized level after edge j: input sampled S-1 edges earlier, or 1 right after reset
   function automatic bit s_at(int j);
      if (j - S + 1 <= rst_edge) return 1'b1;
      return samp[(j - S + 1) % MAXE];
   endfunction

   always @(posedge clk) begin : model
      bit r, f;
      int p;
      k = k + 1;
      samp[k % MAXE] = sig_in;
      exp_mv = 1'b0;
      if (reset) begin
         rst_edge = k; seeking = 1'b1; have_prev = 1'b0; fall_seen = 1'b0;
         match = 0; exp_period = 0; exp_high = 0; exp_timeout = 1'b0;
      end else begin
         r = s_at(k - 1) && !s_at(k - 2);
         f = !s_at(k - 1) && s_at(k - 2);
         if (seeking) begin
            if (r) begin
               seeking = 1'b0; exp_timeout = 1'b0; start_k = k; fall_seen = 1'b0;
            end
         end else if (r) begin
            p = k - start_k;
            if (have_prev && p == exp_period) match = (match < LC) ? match + 1 : LC;
            else match = 1;
            exp_period = p;
            exp_high   = DUTY ? (fall_seen ? fall_k - start_k : p) : 0;
            exp_mv     = 1'b1;
            have_prev  = 1'b1;
            start_k    = k;
            fall_seen  = 1'b0;
         end else if (k - start_k == TM) begin
            exp_timeout = 1'b1; match = 0; have_prev = 1'b0; seeking = 1'b1;
         end else if (f) begin
            fall_seen = 1'b1; fall_k = k;
         end
      end
   end

   int wper = 10, whi = 5, wph = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wave_step();
      sig_in = (wph < whi);
      wph    = (wph + 1) % wper;
      tick();
   endtask

   task automatic test_reset();
      int mv_seen = 0;
      reset = 1'b1; sig_in = 1'b1;
      repeat (3) tick();
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_state: got %h want 0", obs); end
      reset = 1'b0;
      repeat (15) begin
         tick();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL hold_high: got %h want %h", obs, expv); end
         if (meas_valid) mv_seen++;
      end
      checks++;
      if (mv_seen != 0) begin errors++; $display("FAIL no_false_rise: got %0d pulses want 0", mv_seen); end
      sig_in = 1'b0;
      repeat (5) begin
         tick();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL release_low: got %h want %h", obs, expv); end
      end
   endtask

   task automatic test_divider();
      int mvc = 0, lock_at = 0;
      wper = 10; whi = 5; wph = 0;
      repeat (80) begin
         wave_step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL divider: got %h want %h", obs, expv); end
         if (meas_valid) begin
            mvc++;
            if (locked && lock_at == 0) lock_at = mvc;
         end
      end
      checks++;
      if (lock_at != 4) begin errors++; $display("FAIL divider_lock_at: got %0d want 4", lock_at); end
      checks++;
      if (period !== W'(10) || high_time !== W'(DUTY ? 5 : 0) || timeout !== 1'b0) begin
         errors++;
         $display("FAIL divider_result: got per=%0d hi=%0d to=%0b want 10 %0d 0", period, high_time, timeout, DUTY ? 5 : 0);
      end
   endtask

   task automatic test_ratio_change();
      int idx = 0, drop_at = 0, relock_at = 0;
      while (wph != 0) begin
         wave_step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL ratio_align: got %h want %h", obs, expv); end
      end
      wper = 12; whi = 6;
      repeat (100) begin
         wave_step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL ratio_change: got %h want %h", obs, expv); end
         if (meas_valid) begin
            idx++;
            if (!locked && drop_at == 0) drop_at = idx;
            else if (locked && drop_at != 0 && relock_at == 0) relock_at = idx;
         end
      end
      checks++;
      if (drop_at != 2 || relock_at != 5) begin
         errors++;
         $display("FAIL ratio_lock: got drop=%0d relock=%0d want 2 5", drop_at, relock_at);
      end
   endtask

   task automatic test_timeout();
      int last_mv_k = 0, to_k = 0, clr_k = 0, mv_k = 0;
      while (wph != 0) begin
         wave_step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL timeout_align: got %h want %h", obs, expv); end
      end
      wper = 10; whi = 5;
      repeat (60) begin
         wave_step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL timeout_relock: got %h want %h", obs, expv); end
         if (meas_valid) last_mv_k = k;
      end
      sig_in = 1'b0;
      repeat (150) begin
         tick();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL timeout_idle: got %h want %h", obs, expv); end
         if (meas_valid) last_mv_k = k;
         if (timeout && to_k == 0) begin
            to_k = k;
            checks++;
            if (locked !== 1'b0 || period !== W'(10)) begin
               errors++; $display("FAIL timeout_hold: got lk=%0b per=%0d want 0 10", locked, period);
            end
         end
      end
      checks++;
      if (to_k == 0 || to_k - last_mv_k != TM) begin
         errors++; $display("FAIL timeout_delay: got %0d want %0d", to_k - last_mv_k, TM);
      end
      wph = 0;
      repeat (30) begin
         wave_step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL timeout_restart: got %h want %h", obs, expv); end
         if (!timeout && clr_k == 0) clr_k = k;
         if (meas_valid && mv_k == 0) mv_k = k;
      end
      checks++;
      if (clr_k == 0 || mv_k - clr_k != 10) begin
         errors++; $display("FAIL timeout_clear: got %0d cycles want 10", mv_k - clr_k);
      end
   endtask

   task automatic test_odd_latency();
      int drive_k, mv_k = 0;
      reset = 1'b1; sig_in = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      repeat (4) begin
         tick();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL odd_idle: got %h want %h", obs, expv); end
      end
      wper = 7; whi = 3; wph = 0;
      drive_k = k;
      repeat (60) begin
         wave_step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL odd_ratio: got %h want %h", obs, expv); end
         if (meas_valid && mv_k == 0) mv_k = k;
      end
      checks++;
      if (mv_k - drive_k != S + 1 + 7) begin
         errors++; $display("FAIL odd_latency: got %0d want %0d", mv_k - drive_k, S + 1 + 7);
      end
      checks++;
      if (period !== W'(7) || high_time !== W'(DUTY ? 3 : 0)) begin
         errors++; $display("FAIL odd_result: got per=%0d hi=%0d want 7 %0d", period, high_time, DUTY ? 3 : 0);
      end
   endtask

   task automatic test_reset_mid();
      repeat (3) begin
         wave_step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL mid_pre: got %h want %h", obs, expv); end
      end
      reset = 1'b1;
      wave_step();
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL mid_reset: got %h want 0", obs); end
      reset = 1'b0;
      repeat (50) begin
         wave_step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL mid_recover: got %h want %h", obs, expv); end
      end
   endtask

   task automatic test_boundary();
      int to_seen = 0;
      wper = 2; whi = 1; wph = 0;
      repeat (30) begin
         wave_step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL min_period: got %h want %h", obs, expv); end
      end
      checks++;
      if (period !== W'(2) || high_time !== W'(DUTY ? 1 : 0)) begin
         errors++; $display("FAIL min_result: got per=%0d hi=%0d want 2 %0d", period, high_time, DUTY ? 1 : 0);
      end
      wper = TM; whi = 50; wph = 0;
      repeat (3 * TM + 10) begin
         wave_step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL max_period: got %h want %h", obs, expv); end
         if (timeout) to_seen++;
      end
      checks++;
      if (period !== W'(TM) || to_seen != 0) begin
         errors++; $display("FAIL max_result: got per=%0d timeouts=%0d want %0d 0", period, to_seen, TM);
      end
      wper = TM + 1; whi = 1; wph = 0;
      repeat (3 * (TM + 1)) begin
         wave_step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL over_period: got %h want %h", obs, expv); end
         if (timeout) to_seen++;
      end
      checks++;
      if (to_seen < 2) begin errors++; $display("FAIL over_timeout: got %0d cycles want >=2", to_seen); end
   endtask

   task automatic test_random();
      int len;
      repeat (10) begin
         wper = $urandom_range(2, 24);
         whi  = $urandom_range(1, wper - 1);
         wph  = 0;
         len  = $urandom_range(30, 120);
         if ($urandom_range(0, 7) == 0) reset = 1'b1;
         repeat (len) begin
            wave_step();
            reset = 1'b0;
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL random_wave: got %h want %h", obs, expv); end
         end
         if ($urandom_range(0, 3) == 0) begin
            sig_in = 1'b0;
            repeat ($urandom_range(60, 140)) begin
               tick();
               checks++;
               if (obs !== expv) begin errors++; $display("FAIL random_gap: got %h want %h", obs, expv); end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_divider();
      test_ratio_change();
      test_timeout();
      test_odd_latency();
      test_reset_mid();
      test_boundary();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
